nios_system_cpu_oci_access_arbiter: RTL and testbench

NIOS_SYSTEM_CPU_OCI_ACCESS_ARBITER -- requirements
Module: nios_system_cpu_oci_access_arbiter

---
 rtl/nios_system_cpu_oci_access_arbiter.sv | 131 +++++++++++++
 tb/tb_nios_system_cpu_oci_access_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_cpu_oci_access_arbiter.sv
// Shares one OCI RAM port between the JTAG debug side and the CPU Avalon slave; grants take 3 cycles (IDLE, ACCESS, RESP).
// Backpressure: the loser stalls (jtag_req held, av_waitrequest high). Build option OCI_ARB_JTAG_PRIORITY_EN gives JTAG strict priority over round-robin.
module nios_system_cpu_oci_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic              jtag_ack,
    output logic [DATA_W-1:0] jtag_rdata,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0] av_writedata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic GNT_JTAG = 1'b0;
    localparam logic GNT_AV   = 1'b1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant;
    logic              r_win;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_jtag_rdata;

    logic w_av_req;
    logic w_any_req;
    logic w_pick_jtag;
    logic w_resp_av;

    assign w_av_req  = av_read | av_write;
    assign w_any_req = jtag_req | w_av_req;

`ifdef OCI_ARB_JTAG_PRIORITY_EN
    assign w_pick_jtag = jtag_req;
`else
    // On a tie, whoever was not granted last goes next.
    assign w_pick_jtag = jtag_req & (~w_av_req | (r_last_grant == GNT_AV));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GNT_AV;
            r_win        <= GNT_JTAG;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_jtag_rdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_win        <= w_pick_jtag ? GNT_JTAG : GNT_AV;
                r_last_grant <= w_pick_jtag ? GNT_JTAG : GNT_AV;
                // read+write together from Avalon is a write
                r_wr         <= w_pick_jtag ? jtag_wr    : av_write;
                r_addr       <= w_pick_jtag ? jtag_addr  : av_address;
                r_wdata      <= w_pick_jtag ? jtag_wdata : av_writedata;
            end
            if ((r_state == S_RESP) && (r_win == GNT_JTAG) && !r_wr) begin
                r_jtag_rdata <= ram_rdata;
            end
        end
    end

    assign w_resp_av = (r_state == S_RESP) && (r_win == GNT_AV);

    always_comb begin
        w_next_state   = r_state;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        jtag_ack       = 1'b0;
        av_waitrequest = w_av_req & ~w_resp_av;
        av_readdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en       = 1'b1;
                ram_we       = r_wr;
                ram_addr     = r_addr;
                ram_wdata    = r_wdata;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                jtag_ack = (r_win == GNT_JTAG);
                if (w_resp_av) begin
                    av_readdata = ram_rdata;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign jtag_rdata = r_jtag_rdata;

endmodule

// File: tb/tb_nios_system_cpu_oci_access_arbiter.sv
// Bench for the OCI access arbiter: directed cases, alternation/priority run and random traffic from both masters,
// checked by a completion monitor against a word-array memory model.
module tb_nios_system_cpu_oci_access_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          jtag_req, jtag_wr;
    logic [AW-1:0] jtag_addr;
    logic [DW-1:0] jtag_wdata;
    logic          jtag_ack;
    logic [DW-1:0] jtag_rdata;
    logic          av_read, av_write;
    logic [AW-1:0] av_address;
    logic [DW-1:0] av_writedata;
    logic          av_waitrequest;
    logic [DW-1:0] av_readdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    nios_system_cpu_oci_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .jtag_ack(jtag_ack), .jtag_rdata(jtag_rdata),
        .av_read(av_read), .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // RAM attached to the arbiter: one-cycle read latency
    logic [DW-1:0] mem [0:255];
    bit            ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            ram_rdata <= '0;
            ram_init  <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          jq[$];
    txn_t          aq[$];
    logic [DW-1:0] model [0:255];
    logic [DW-1:0] exp_jrdata;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            log_en = 1'b0;
    int            owners[$];
    int            times[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Completion monitor: every completion pops the oldest outstanding request of that master.
    initial begin : monitor
        logic          p_en, p_we, av_done;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        txn_t          t;
        for (int i = 0; i < 256; i++) model[i] = '0;
        exp_jrdata = '0;
        p_en = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_jrdata = '0;
                p_en = 1'b0;
            end else begin
                chk("jtag_rdata_hold", jtag_rdata, exp_jrdata);
                av_done = (av_read | av_write) && !av_waitrequest;
                if (!ram_en) chk("ram_idle_zero", {ram_we, ram_addr, ram_wdata}, 64'd0);
                if (!(av_read | av_write)) chk("av_wait_noreq", av_waitrequest, 1'b0);
                if (!av_done) chk("av_rdata_idle", av_readdata, 0);
                if (jtag_ack && av_done) fail("double_completion");
                if (jtag_ack) begin
                    if (jq.size() == 0) fail("jtag_unexpected_ack");
                    else begin
                        t = jq.pop_front();
                        chk("jtag_ram_en", p_en, 1'b1);
                        chk("jtag_ram_addr", p_addr, t.addr);
                        chk("jtag_ram_we", p_we, t.wr);
                        if (t.wr) begin
                            chk("jtag_ram_wdata", p_wdata, t.wdata);
                            model[t.addr] = t.wdata;
                        end else begin
                            exp_jrdata = model[t.addr];
                        end
                        if (log_en) begin owners.push_back(0); times.push_back(cyc); end
                    end
                end else if (av_done) begin
                    if (aq.size() == 0) fail("av_unexpected_release");
                    else begin
                        t = aq.pop_front();
                        chk("av_ram_en", p_en, 1'b1);
                        chk("av_ram_addr", p_addr, t.addr);
                        chk("av_ram_we", p_we, t.wr);
                        if (t.wr) begin
                            chk("av_ram_wdata", p_wdata, t.wdata);
                            model[t.addr] = t.wdata;
                        end else begin
                            chk("av_readdata", av_readdata, model[t.addr]);
                        end
                        if (log_en) begin owners.push_back(1); times.push_back(cyc); end
                    end
                end
                p_en = ram_en; p_we = ram_we; p_addr = ram_addr; p_wdata = ram_wdata;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the request dropped. lat = cycles seen without ack.
    task automatic jtag_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        bit done;
        jtag_req = 1'b1; jtag_wr = wr; jtag_addr = a; jtag_wdata = d;
        jq.push_back('{wr, a, d});
        lat = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (jtag_ack) done = 1'b1;
            else begin
                lat++;
                if (lat > 200) begin fail("jtag_timeout"); done = 1'b1; end
            end
        end
        @(posedge clk); #1;
        jtag_req = 1'b0;
    endtask

    task automatic av_txn(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat);
        bit done;
        av_read = rd; av_write = wr; av_address = a; av_writedata = d;
        aq.push_back('{wr, a, d});
        lat = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!av_waitrequest) done = 1'b1;
            else begin
                lat++;
                if (lat > 200) begin fail("av_timeout"); done = 1'b1; end
            end
        end
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic jtag_rand(input int n, input bit gaps);
        int lat;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            jtag_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom, lat);
        end
    endtask

    task automatic av_rand(input int n, input bit gaps, output int first_lat);
        int lat, mode;
        first_lat = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            mode = $urandom_range(0, 2);
            av_txn(1'(mode != 1), 1'(mode != 0), AW'($urandom_range(0, 7)), $urandom, lat);
            if (i == 0) first_lat = lat;
        end
    endtask

    initial begin : main
        int lat, av_first, n;
        bit seen;
        reset = 1'b1;
        jtag_req = 0; jtag_wr = 0; jtag_addr = '0; jtag_wdata = '0;
        av_read = 0; av_write = 0; av_address = '0; av_writedata = '0;
        #1;
        chk("rst_jtag_ack", jtag_ack, 1'b0);
        chk("rst_jtag_rdata", jtag_rdata, 0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_av_wait", av_waitrequest, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        jtag_txn(1'b1, 8'h10, 32'hDEADBEEF, lat);
        chk("jtag_wr_latency", lat, 2);
        chk("ram_word_10", mem[8'h10], 32'hDEADBEEF);
        av_txn(1'b1, 1'b0, 8'h10, '0, lat);
        chk("av_rd_wait_cycles", lat, 2);
        av_txn(1'b1, 1'b1, 8'h05, 32'h1, lat);
        chk("av_rdwr_wait_cycles", lat, 2);
        chk("ram_word_05", mem[8'h05], 32'h1);
        jtag_txn(1'b0, 8'h10, '0, lat);
        chk("jtag_rd_latency", lat, 2);
        @(negedge clk);
        chk("jtag_rdata_direct", jtag_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset in the middle of a JTAG read: nothing queued, so any ack is flagged by the monitor.
        jtag_req = 1'b1; jtag_wr = 1'b0; jtag_addr = 8'h10;
        n = 0; seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            if (ram_en) seen = 1'b1;
            n++;
        end
        if (!seen) fail("abort_no_access");
        #1 reset = 1'b1;
        #1;
        chk("abort_ram_en", ram_en, 1'b0);
        chk("abort_jtag_rdata", jtag_rdata, 0);
        chk("abort_jtag_ack", jtag_ack, 1'b0);
        jtag_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_ack", jtag_ack, 1'b0);
        end
        @(posedge clk); #1;

        // Both masters back to back straight after reset.
        do_reset();
        owners.delete(); times.delete();
        log_en = 1'b1;
        fork
            jtag_rand(6, 1'b0);
            av_rand(6, 1'b0, av_first);
        join
        log_en = 1'b0;
        chk("alt_count", owners.size(), 12);
        for (int i = 0; i < owners.size(); i++) begin
`ifdef OCI_ARB_JTAG_PRIORITY_EN
            chk("prio_owner", owners[i], (i < 6) ? 0 : 1);
`else
            chk("rr_owner", owners[i], i % 2);
`endif
            if (i > 0) chk("grant_spacing", times[i] - times[i-1], 3);
        end
`ifdef OCI_ARB_JTAG_PRIORITY_EN
        chk("prio_av_first_wait", av_first, 20);
`else
        chk("rr_av_first_wait", av_first, 5);
`endif

        fork
            jtag_rand(40, 1'b1);
            av_rand(40, 1'b1, av_first);
        join

        repeat (5) @(posedge clk);
        #1;
        chk("jq_drained", jq.size(), 0);
        chk("aq_drained", aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
